// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one registered-read data memory between LSU (p0) and debug/DMA (p1), with RMW lock.
// Latency: grant combinational in the request cycle; read data returned exactly one cycle after grant.
// Backpressure: a losing or locked-out requester holds req until gnt; responses cannot be stalled.
module data_memory_arbiter #(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic                  p0_lock,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [3:0]            p0_be,
  input  logic [31:0]           p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [31:0]           p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic                  p1_lock,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [3:0]            p1_be,
  input  logic [31:0]           p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [31:0]           p1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [3:0]            mem_byteena,
  output logic [31:0]           mem_data,
  output logic                  mem_wren,
  input  logic [31:0]           mem_q
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED0  = 2'd1,
    LOCKED1  = 2'd2
  } lock_state_t;

  lock_state_t state, state_nxt;
  logic        last_gnt;
  logic        rsp_valid;
  logic        rsp_port;

  // The lock owner's own access decides the next lock state, so one rule covers take, keep and release.
  always_comb begin
    p0_gnt    = 1'b0;
    p1_gnt    = 1'b0;
    state_nxt = state;
    if (!reset) begin
      case (state)
        LOCKED0: p0_gnt = p0_req;
        LOCKED1: p1_gnt = p1_req;
        default: begin
          if (p0_req && p1_req) begin
            p0_gnt = last_gnt;
            p1_gnt = !last_gnt;
          end else begin
            p0_gnt = p0_req;
            p1_gnt = p1_req;
          end
        end
      endcase
      if (p0_gnt) begin
        state_nxt = p0_lock ? LOCKED0 : UNLOCKED;
      end else if (p1_gnt) begin
        state_nxt = p1_lock ? LOCKED1 : UNLOCKED;
      end
    end
  end

  always_comb begin
    mem_address = p0_addr;
    mem_data    = p0_wdata;
    mem_byteena = 4'b0000;
    mem_wren    = 1'b0;
    if (p1_gnt) begin
      mem_address = p1_addr;
      mem_data    = p1_wdata;
      mem_byteena = p1_be;
      mem_wren    = p1_we;
    end else if (p0_gnt) begin
      mem_byteena = p0_be;
      mem_wren    = p0_we;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= UNLOCKED;
      last_gnt  <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_port  <= 1'b0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= (p0_gnt && !p0_we) || (p1_gnt && !p1_we);
      rsp_port  <= p1_gnt;
      if (p0_gnt || p1_gnt) begin
        last_gnt <= p1_gnt;
      end
    end
  end

  // Reset also masks a response already in flight so nothing leaks out while reset is high.
  assign p0_rvalid = rsp_valid && !rsp_port && !reset;
  assign p1_rvalid = rsp_valid && rsp_port && !reset;
  assign p0_rdata  = p0_rvalid ? mem_q : 32'h0;
  assign p1_rdata  = p1_rvalid ? mem_q : 32'h0;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: registered-read memory model plus a response scoreboard.
module tb_data_memory_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p0_lock;
  logic [14:0] p0_addr;
  logic [3:0]  p0_be;
  logic [31:0] p0_wdata;
  logic        p0_gnt, p0_rvalid;
  logic [31:0] p0_rdata;
  logic        p1_req, p1_we, p1_lock;
  logic [14:0] p1_addr;
  logic [3:0]  p1_be;
  logic [31:0] p1_wdata;
  logic        p1_gnt, p1_rvalid;
  logic [31:0] p1_rdata;
  logic [14:0] mem_address;
  logic [3:0]  mem_byteena;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic [31:0] mem_q;

  int checks = 0;
  int errors = 0;
  logic [32:0] sb_q[$];   // {port, expected rdata}
  logic [31:0] mem [0:255];

  always #5 clock = ~clock;

  data_memory_arbiter #(.ADDR_WIDTH(15)) dut (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_be(p0_be),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_be(p1_be),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_address(mem_address), .mem_byteena(mem_byteena), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_q(mem_q)
  );

  // Registered-read memory: read samples the old word, then byte writes land.
  always @(posedge clock) begin
    mem_q <= mem[mem_address[7:0]];
    for (int b = 0; b < 4; b++)
      if (mem_wren && mem_byteena[b]) mem[mem_address[7:0]][8*b +: 8] = mem_data[8*b +: 8];
  end

  function automatic logic [31:0] pat(input logic [7:0] a);
    if (a == 8'h10) return 32'hDEADBEEF;
    return {8'hA5, a, ~a, a ^ 8'h3C};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    p0_req = 0; p0_we = 0; p0_lock = 0; p0_be = 4'hF;
    p1_req = 0; p1_we = 0; p1_lock = 0; p1_be = 4'hF;
  endtask

  task automatic test_reset();
    reset = 1; p0_req = 1; p0_we = 1; p1_req = 1; p1_we = 1;
    tick();
    @(negedge clock);
    checks++; if (p0_gnt !== 1'b0) begin errors++; $display("FAIL rst_p0_gnt got %b exp 0", p0_gnt); end
    checks++; if (p1_gnt !== 1'b0) begin errors++; $display("FAIL rst_p1_gnt got %b exp 0", p1_gnt); end
    checks++; if (mem_wren !== 1'b0) begin errors++; $display("FAIL rst_wren got %b exp 0", mem_wren); end
    checks++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b%b exp 00", p0_rvalid, p1_rvalid); end
    checks++; if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h %h exp 0", p0_rdata, p1_rdata); end
    tick();
    reset = 0; idle();
    @(negedge clock);
    checks++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin errors++; $display("FAIL post_rst_rvalid got %b%b exp 00", p0_rvalid, p1_rvalid); end
  endtask

  task automatic test_read_alone();
    logic [32:0] exp;
    tick();
    p0_req = 1; p0_we = 0; p0_addr = 15'h0010;
    @(negedge clock);
    checks++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin errors++; $display("FAIL rd_gnt got %b%b exp 10", p0_gnt, p1_gnt); end
    checks++; if (mem_wren !== 1'b0) begin errors++; $display("FAIL rd_wren got %b exp 0", mem_wren); end
    checks++; if (mem_address !== 15'h0010) begin errors++; $display("FAIL rd_addr got %h exp 0010", mem_address); end
    sb_q.push_back({1'b0, 32'hDEADBEEF});
    tick();
    idle();
    @(negedge clock);
    exp = sb_q.pop_front();
    checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== exp[31:0]) begin errors++; $display("FAIL rd_rsp got %b %h exp 1 %h", p0_rvalid, p0_rdata, exp[31:0]); end
    checks++; if (p1_rvalid !== 1'b0 || p1_rdata !== 32'h0) begin errors++; $display("FAIL rd_other got %b %h exp 0 0", p1_rvalid, p1_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [32:0] exp;
    logic [7:0]  a0, a1;
    logic        w, rv, orv;
    logic [31:0] rd, ord;
    a0 = 8'h01; a1 = 8'h40;
    tick();
    reset = 1; idle();
    tick();
    reset = 0;
    p0_req = 1; p0_we = 0; p0_addr = {7'h0, a0};
    p1_req = 1; p1_we = 0; p1_addr = {7'h0, a1};
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      w = i[0];
      if (i == 6) w = 1'b0;
      if (i < 6) begin
        checks++; if (p0_gnt !== !w || p1_gnt !== w) begin errors++; $display("FAIL alt_gnt%0d got %b%b exp %b%b", i, p0_gnt, p1_gnt, !w, w); end
      end
      if (i > 0) begin
        exp = sb_q.pop_front();
        rv  = exp[32] ? p1_rvalid : p0_rvalid;
        rd  = exp[32] ? p1_rdata  : p0_rdata;
        orv = exp[32] ? p0_rvalid : p1_rvalid;
        ord = exp[32] ? p0_rdata  : p1_rdata;
        checks++;
        if (rv !== 1'b1 || rd !== exp[31:0] || orv !== 1'b0 || ord !== 32'h0) begin
          errors++; $display("FAIL alt_rsp%0d port %0d got %b %h other %b %h exp 1 %h", i, exp[32], rv, rd, orv, ord, exp[31:0]);
        end
      end
      if (i < 6) sb_q.push_back({w, pat(w ? a1 : a0)});
      tick();
      if (w) a1 = a1 + 1; else a0 = a0 + 1;
      p0_addr = {7'h0, a0}; p1_addr = {7'h0, a1};
      if (i == 5) idle();
    end
  endtask

  task automatic test_write();
    logic [32:0] exp;
    idle();
    p1_req = 1; p1_we = 1; p1_be = 4'b0100; p1_wdata = 32'h00AB0000; p1_addr = 15'h0020;
    @(negedge clock);
    checks++; if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0) begin errors++; $display("FAIL wr_gnt got %b%b exp 01", p0_gnt, p1_gnt); end
    checks++; if (mem_wren !== 1'b1 || mem_byteena !== 4'b0100) begin errors++; $display("FAIL wr_ctl got %b %b exp 1 0100", mem_wren, mem_byteena); end
    checks++; if (mem_address !== 15'h0020 || mem_data !== 32'h00AB0000) begin errors++; $display("FAIL wr_bus got %h %h exp 0020 00ab0000", mem_address, mem_data); end
    tick();
    idle();
    p0_req = 1; p0_we = 0; p0_addr = 15'h0020;
    @(negedge clock);
    checks++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin errors++; $display("FAIL wr_norsp got %b%b exp 00", p0_rvalid, p1_rvalid); end
    checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL wr_rb_gnt got %b exp 1", p0_gnt); end
    sb_q.push_back({1'b0, (pat(8'h20) & 32'hFF00FFFF) | 32'h00AB0000});
    tick();
    idle();
    @(negedge clock);
    exp = sb_q.pop_front();
    checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== exp[31:0]) begin errors++; $display("FAIL wr_rb got %b %h exp 1 %h", p0_rvalid, p0_rdata, exp[31:0]); end
  endtask

  task automatic test_lock();
    logic [32:0] exp;
    logic [31:0] rmw;
    tick();
    p0_req = 1; p0_we = 0; p0_lock = 1; p0_addr = 15'h0030;
    @(negedge clock);
    checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL lk_take got %b exp 1", p0_gnt); end
    sb_q.push_back({1'b0, pat(8'h30)});
    tick();
    p0_req = 0; p0_lock = 0;
    p1_req = 1; p1_we = 0; p1_addr = 15'h0030;
    @(negedge clock);
    exp = sb_q.pop_front();
    rmw = exp[31:0] + 32'd1;
    checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== exp[31:0]) begin errors++; $display("FAIL lk_rd got %b %h exp 1 %h", p0_rvalid, p0_rdata, exp[31:0]); end
    checks++; if (p1_gnt !== 1'b0) begin errors++; $display("FAIL lk_hold1 got %b exp 0", p1_gnt); end
    tick();
    @(negedge clock);
    checks++; if (p1_gnt !== 1'b0) begin errors++; $display("FAIL lk_hold2 got %b exp 0", p1_gnt); end
    tick();
    p0_req = 1; p0_we = 1; p0_be = 4'hF; p0_wdata = rmw;
    @(negedge clock);
    checks++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0 || mem_wren !== 1'b1) begin errors++; $display("FAIL lk_wr got %b%b wren %b exp 10 1", p0_gnt, p1_gnt, mem_wren); end
    tick();
    p0_req = 0; p0_we = 0;
    @(negedge clock);
    checks++; if (p1_gnt !== 1'b1) begin errors++; $display("FAIL lk_release got %b exp 1", p1_gnt); end
    sb_q.push_back({1'b1, rmw});
    tick();
    idle();
    @(negedge clock);
    exp = sb_q.pop_front();
    checks++; if (p1_rvalid !== 1'b1 || p1_rdata !== exp[31:0] || p0_rvalid !== 1'b0) begin errors++; $display("FAIL lk_result got %b %h exp 1 %h", p1_rvalid, p1_rdata, exp[31:0]); end
  endtask

  task automatic test_reset_locked();
    logic [32:0] exp;
    tick();
    p1_req = 1; p1_we = 0; p1_lock = 1; p1_addr = 15'h0005;
    @(negedge clock);
    checks++; if (p1_gnt !== 1'b1) begin errors++; $display("FAIL rl_take got %b exp 1", p1_gnt); end
    tick();
    reset = 1; idle();
    @(negedge clock);
    checks++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0 || p1_rdata !== 32'h0) begin errors++; $display("FAIL rl_drop got %b%b %h exp 00 0", p0_rvalid, p1_rvalid, p1_rdata); end
    tick();
    reset = 0;
    p0_req = 1; p0_we = 0; p0_addr = 15'h0006;
    p1_req = 1; p1_we = 0; p1_addr = 15'h0007;
    @(negedge clock);
    checks++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin errors++; $display("FAIL rl_first got %b%b exp 10", p0_gnt, p1_gnt); end
    checks++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin errors++; $display("FAIL rl_stale got %b%b exp 00", p0_rvalid, p1_rvalid); end
    sb_q.push_back({1'b0, pat(8'h06)});
    tick();
    p0_req = 0;
    @(negedge clock);
    checks++; if (p1_gnt !== 1'b1) begin errors++; $display("FAIL rl_unlocked got %b exp 1", p1_gnt); end
    exp = sb_q.pop_front();
    checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== exp[31:0]) begin errors++; $display("FAIL rl_rsp0 got %b %h exp 1 %h", p0_rvalid, p0_rdata, exp[31:0]); end
    sb_q.push_back({1'b1, pat(8'h07)});
    tick();
    idle();
    @(negedge clock);
    exp = sb_q.pop_front();
    checks++; if (p1_rvalid !== 1'b1 || p1_rdata !== exp[31:0]) begin errors++; $display("FAIL rl_rsp1 got %b %h exp 1 %h", p1_rvalid, p1_rdata, exp[31:0]); end
  endtask

  task automatic test_lock_idle();
    logic [32:0] exp;
    tick();
    p0_req = 1; p0_we = 0; p0_lock = 1; p0_addr = 15'h0008;
    @(negedge clock);
    checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL li_take got %b exp 1", p0_gnt); end
    sb_q.push_back({1'b0, pat(8'h08)});
    tick();
    p0_req = 0;
    p1_req = 1; p1_we = 1; p1_be = 4'hF; p1_wdata = 32'h12345678; p1_addr = 15'h0009;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0 || mem_wren !== 1'b0) begin errors++; $display("FAIL li_idle%0d got %b%b wren %b exp 00 0", i, p0_gnt, p1_gnt, mem_wren); end
      if (i == 0) begin
        exp = sb_q.pop_front();
        checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== exp[31:0]) begin errors++; $display("FAIL li_rsp got %b %h exp 1 %h", p0_rvalid, p0_rdata, exp[31:0]); end
      end
      tick();
    end
    p0_req = 1; p0_lock = 0;
    @(negedge clock);
    checks++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin errors++; $display("FAIL li_unlock got %b%b exp 10", p0_gnt, p1_gnt); end
    sb_q.push_back({1'b0, pat(8'h08)});
    tick();
    p0_req = 0;
    @(negedge clock);
    checks++; if (p1_gnt !== 1'b1 || mem_wren !== 1'b1) begin errors++; $display("FAIL li_p1 got %b wren %b exp 1 1", p1_gnt, mem_wren); end
    exp = sb_q.pop_front();
    checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== exp[31:0]) begin errors++; $display("FAIL li_rsp2 got %b %h exp 1 %h", p0_rvalid, p0_rdata, exp[31:0]); end
    tick();
    p1_we = 0;
    @(negedge clock);
    checks++; if (p1_gnt !== 1'b1 || p1_rvalid !== 1'b0) begin errors++; $display("FAIL li_rd got %b rvalid %b exp 1 0", p1_gnt, p1_rvalid); end
    sb_q.push_back({1'b1, 32'h12345678});
    tick();
    idle();
    @(negedge clock);
    exp = sb_q.pop_front();
    checks++; if (p1_rvalid !== 1'b1 || p1_rdata !== exp[31:0]) begin errors++; $display("FAIL li_wdata got %b %h exp 1 %h", p1_rvalid, p1_rdata, exp[31:0]); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = pat(i[7:0]);
    idle();
    p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
    reset = 1;
    test_reset();
    test_read_alone();
    test_back_to_back();
    test_write();
    test_lock();
    test_reset_locked();
    test_lock_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
